// File: rtl/bram_frame_reader.sv
// Purpose: scans a captured 1-bit frame out of the capture BRAM in raster order as a pixel stream with x/y and sof/eol/eof.
// Latency: start sampled at T, read_addr=0 at T+1, first beat (y_sof) valid at T+3; one beat per cycle when unstalled.
// Backpressure: 2-entry output buffer; reads stall once buffer plus the in-flight read would exceed 2 entries.
module bram_frame_reader #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW    = $clog2(TOTAL),
  localparam int XW    = $clog2(IMG_WIDTH),
  localparam int YW    = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          frame_valid,
  output logic [AW-1:0] read_addr,
  input  logic          read_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [7:0]    y_data,
  output logic [XW-1:0] y_x,
  output logic [YW-1:0] y_y,
  output logic          y_sof,
  output logic          y_eol,
  output logic          y_eof,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FINISH
  } state_t;

  // One buffered output beat; flags are computed when the beat is written.
  typedef struct packed {
    logic          dat;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  state_t        state;

  // Issue side: next address/coordinates to read, plus the tag of the read in flight.
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] last_addr;
  logic [XW-1:0] ix;
  logic [YW-1:0] iy;
  logic          all_issued;
  logic          inflight;
  logic [XW-1:0] tag_x;
  logic [YW-1:0] tag_y;

  // Output buffer: head drives the y_* port, skid holds the second entry.
  beat_t         head;
  beat_t         skid;
  logic          h_vld;
  logic          s_vld;
  beat_t         in_beat;

  logic          go;
  logic          abort;
  logic          pop;
  logic          issue;
  logic [2:0]    slots_used;
  logic [2:0]    slots_cap;

  // Control decisions for this cycle; abort overrides issue and buffer updates.
  always_comb begin
    go         = (state == S_IDLE) && start && frame_valid;
    abort      = (state == S_STREAM) && !frame_valid;
    pop        = h_vld && y_ready;
    slots_used = {2'b00, h_vld} + {2'b00, s_vld} + {2'b00, inflight};
    // A beat leaving this cycle frees a slot for a read issued this cycle.
    slots_cap  = pop ? 3'd3 : 3'd2;
    issue      = (state == S_STREAM) && frame_valid && !all_issued && (slots_used < slots_cap);
    read_addr  = issue ? issue_addr : last_addr;
  end

  // Beat arriving from the BRAM, one cycle after its read was issued.
  always_comb begin
    in_beat     = '0;
    in_beat.dat = read_data;
    in_beat.x   = tag_x;
    in_beat.y   = tag_y;
    in_beat.sof = (tag_x == '0) && (tag_y == '0);
    in_beat.eol = (tag_x == X_MAX);
    in_beat.eof = (tag_x == X_MAX) && (tag_y == Y_MAX);
  end

  // Top-level state machine with registered done/aborted pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) state <= S_STREAM;
        end
        S_STREAM: begin
          if (!frame_valid) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else if (pop && head.eof) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Read issue counter: raster-order address and x/y, and the in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_addr <= '0;
      last_addr  <= '0;
      ix         <= '0;
      iy         <= '0;
      all_issued <= 1'b0;
      inflight   <= 1'b0;
      tag_x      <= '0;
      tag_y      <= '0;
    end else if (go) begin
      issue_addr <= '0;
      ix         <= '0;
      iy         <= '0;
      all_issued <= 1'b0;
      inflight   <= 1'b0;
    end else if (abort) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        last_addr <= issue_addr;
        tag_x     <= ix;
        tag_y     <= iy;
        // Last pixel: park the counters instead of wrapping.
        if (issue_addr == LAST_ADDR) begin
          all_issued <= 1'b1;
        end else begin
          issue_addr <= issue_addr + AW'(1);
          if (ix == X_MAX) begin
            ix <= '0;
            iy <= iy + YW'(1);
          end else begin
            ix <= ix + XW'(1);
          end
        end
      end
    end
  end

  // Two-entry output buffer; head holds steady until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_vld <= 1'b0;
      s_vld <= 1'b0;
      head  <= '0;
      skid  <= '0;
    end else if (go || abort) begin
      h_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (pop) begin
      if (s_vld) begin
        head  <= skid;
        s_vld <= inflight;
        if (inflight) skid <= in_beat;
      end else begin
        h_vld <= inflight;
        if (inflight) head <= in_beat;
      end
    end else if (inflight) begin
      if (!h_vld) begin
        h_vld <= 1'b1;
        head  <= in_beat;
      end else begin
        s_vld <= 1'b1;
        skid  <= in_beat;
      end
    end
  end

  // Output port mapping.
  always_comb begin
    y_valid = h_vld;
    y_data  = head.dat ? 8'd255 : 8'd0;
    y_x     = head.x;
    y_y     = head.y;
    y_sof   = head.sof;
    y_eol   = head.eol;
    y_eof   = head.eof;
    busy    = (state != S_IDLE);
  end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Purpose: directed bench for bram_frame_reader on a 4x3 frame with a registered BRAM model.
// Latency: checks exact first-beat and done timing, then streams under random backpressure.
// Backpressure: y_ready driven from the bench; stalled beats must hold stable.
module tb_bram_frame_reader;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       frame_valid;
  logic [3:0] read_addr;
  logic       read_data;
  logic       y_valid;
  logic       y_ready;
  logic [7:0] y_data;
  logic [1:0] y_x;
  logic [1:0] y_y;
  logic       y_sof;
  logic       y_eol;
  logic       y_eof;
  logic       busy;
  logic       done;
  logic       aborted;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] mem;
  logic [14:0] got_beat;

  bram_frame_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_valid(frame_valid),
    .read_addr(read_addr), .read_data(read_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_x(y_x), .y_y(y_y),
    .y_sof(y_sof), .y_eol(y_eol), .y_eof(y_eof),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Registered BRAM read port model.
  always @(posedge clk) begin
    if (int'(read_addr) < N) read_data <= mem[read_addr];
    else read_data <= 1'b0;
  end

  assign got_beat = {y_data, y_x, y_y, y_sof, y_eol, y_eof};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_beat(input int k);
    logic [1:0] x;
    logic [1:0] y;
    x = 2'(k % W);
    y = 2'(k / W);
    return {(mem[k] ? 8'd255 : 8'd0), x, y, (k == 0), ((k % W) == W - 1), (k == N - 1)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a readout and follows it to done, checking every accepted beat.
  task automatic run_frame(input int ready_pct, input bit poke_start, input string tag);
    int idx;
    int dones;
    int cyc;
    int extra;
    logic [14:0] held;
    bit stalled;
    idx = 0; dones = 0; cyc = 0; extra = 0; stalled = 0; held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (dones == 0 && cyc < 400) begin
      if (stalled) check_eq({tag, " hold"}, {16'h0, y_valid, got_beat}, {16'h0, 1'b1, held});
      start = (poke_start && cyc == 4);
      y_ready = ($urandom_range(0, 99) < ready_pct);
      if (y_valid && y_ready) begin
        if (idx < N) check_eq({tag, " beat"}, {17'h0, got_beat}, {17'h0, exp_beat(idx)});
        else check_eq({tag, " extra beat"}, 32'd1, 32'd0);
        idx++;
      end
      stalled = y_valid && !y_ready;
      held = got_beat;
      tick();
      cyc++;
      if (done) dones++;
    end
    start = 1'b0;
    check_eq({tag, " timeout"}, {31'h0, cyc < 400}, 32'd1);
    check_eq({tag, " beat count"}, idx, N);
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (y_valid || done) extra++;
    end
    check_eq({tag, " quiet after done"}, extra, 0);
    check_eq({tag, " idle after done"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; frame_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0);
    tick(); tick();
    check_eq("reset y_valid", {31'h0, y_valid}, 32'd0);
    check_eq("reset beat", {17'h0, got_beat}, 32'd0);
    check_eq("reset read_addr", {28'h0, read_addr}, 32'd0);
    check_eq("reset busy/done/aborted", {29'h0, busy, done, aborted}, 32'd0);
    rst = 1'b0;
    tick();

    // Exact timing with y_ready=1 and an alternating frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("T+1 busy", {31'h0, busy}, 32'd1);
    check_eq("T+1 read_addr", {28'h0, read_addr}, 32'd0);
    check_eq("T+1 y_valid", {31'h0, y_valid}, 32'd0);
    tick();
    check_eq("T+2 y_valid", {31'h0, y_valid}, 32'd0);
    tick();
    for (int k = 0; k < N; k++) begin
      check_eq("t1 valid", {31'h0, y_valid}, 32'd1);
      check_eq("t1 beat", {17'h0, got_beat}, {17'h0, exp_beat(k)});
      check_eq("t1 done early", {31'h0, done}, 32'd0);
      tick();
    end
    check_eq("T+15 done", {31'h0, done}, 32'd1);
    check_eq("T+15 busy", {31'h0, busy}, 32'd1);
    check_eq("T+15 y_valid", {31'h0, y_valid}, 32'd0);
    tick();
    check_eq("T+16 done", {31'h0, done}, 32'd0);
    check_eq("T+16 busy", {31'h0, busy}, 32'd0);

    // Random backpressure at 30% ready.
    run_frame(30, 1'b0, "bp30");

    // start with frame_valid low is ignored.
    frame_valid = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("nofv busy", {31'h0, busy}, 32'd0);
      check_eq("nofv y_valid", {31'h0, y_valid}, 32'd0);
    end
    start = 1'b0;
    frame_valid = 1'b1;
    tick();

    // Second start while busy must not disturb the frame.
    mem = 12'b1100_0110_1011;
    run_frame(100, 1'b1, "restart");
    run_frame(50, 1'b0, "bp50");

    // Abort after 5 accepted beats.
    mem = 12'b0011_1010_0101;
    y_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("abort pre beat", {16'h0, y_valid, got_beat}, {16'h0, 1'b1, exp_beat(k)});
      tick();
    end
    frame_valid = 1'b0;
    y_ready = 1'b0;
    tick();
    check_eq("abort y_valid", {31'h0, y_valid}, 32'd0);
    check_eq("abort pulse", {31'h0, aborted}, 32'd1);
    check_eq("abort done", {31'h0, done}, 32'd0);
    check_eq("abort busy", {31'h0, busy}, 32'd0);
    frame_valid = 1'b1;
    tick();
    check_eq("abort pulse width", {31'h0, aborted}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort no done", {30'h0, done, y_valid}, 32'd0);
    run_frame(100, 1'b0, "after abort");

    // Reset mid-frame with two beats buffered.
    y_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre-rst head", {16'h0, y_valid, got_beat}, {16'h0, 1'b1, exp_beat(0)});
    check_eq("pre-rst read_addr", {28'h0, read_addr}, 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rst y_valid", {31'h0, y_valid}, 32'd0);
    check_eq("rst beat", {17'h0, got_beat}, 32'd0);
    check_eq("rst read_addr", {28'h0, read_addr}, 32'd0);
    check_eq("rst busy/done/aborted", {29'h0, busy, done, aborted}, 32'd0);
    rst = 1'b0;
    tick();
    run_frame(100, 1'b0, "after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
